ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: it sends one command byte to the keyboard, for example 0xED to set the LEDs or 0xFF to reset. It is the opposite direction of the existing PS/2 receive path (KeyboardDecoder), which owns the same inout PS2_CLK/PS2_DATA pins. The block performs the host request-to-send sequence, shifts out 8 data bits, odd parity and stop on device-generated clocks, then checks the device acknowledge. The pins are open-drain, and the top level builds the tri-states from the `*_oe` outputs.

---
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. It performs request-to-send, shifts out data, parity
// and stop on device clocks, then checks the device acknowledge. The pins are driven open-drain.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       rx_hold,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StWaitIdle
  } state_e;

  state_e          state_q;
  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            data_s1_q, data_s2_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [3:0]      idx_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [ToW-1:0]  to_cnt_q;
  logic            fall;

  // Synchronizers reset to the idle-high bus level so reset release cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_i;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign rx_hold = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      idx_q       <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_valid) begin
            shift_q     <= tx_data;
            parity_q    <= ~^tx_data;
            inh_cnt_q   <= '0;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            state_q     <= StInhibit;
          end
        end

        StInhibit: begin
          if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
            inh_cnt_q   <= '0;
            ps2_data_oe <= 1'b1;
            state_q     <= StReq;
          end else begin
            inh_cnt_q <= inh_cnt_q + InhW'(1);
          end
        end

        // Start bit is already on the line; releasing the clock hands clocking to the device.
        StReq: begin
          ps2_clk_oe <= 1'b0;
          idx_q      <= '0;
          to_cnt_q   <= '0;
          state_q    <= StSend;
        end

        StSend: begin
          if (fall) begin
            to_cnt_q <= '0;
            idx_q    <= idx_q + 4'd1;
            if (idx_q < 4'd8) begin
              ps2_data_oe <= ~shift_q[idx_q[2:0]];
            end else if (idx_q == 4'd8) begin
              ps2_data_oe <= ~parity_q;
            end else if (idx_q == 4'd9) begin
              ps2_data_oe <= 1'b0;
            end else if (!data_s2_q) begin
              state_q <= StWaitIdle;
            end else begin
              err      <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end
          end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            err         <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state_q     <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end

        StWaitIdle: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (clk_s2_q && data_s2_q) begin
            done     <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end else if (fall) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            err      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end

        default: begin
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain device model clocks the frame out and acks,
// nacks or stalls the transfer.
module tb_ps2_host_tx;

  localparam int unsigned Inh  = 100;
  localparam int unsigned To   = 400;
  localparam int unsigned Half = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, rx_hold, done, err, clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       pin_clk, pin_data;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  // Wired-AND open-drain bus.
  assign pin_clk  = dev_clk & ~clk_oe;
  assign pin_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .rx_hold    (rx_hold),
    .done       (done),
    .err        (err),
    .ps2_clk_i  (pin_clk),
    .ps2_data_i (pin_data),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe)
  );

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(posedge clk);
    #1 tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rts();
    int w = 0;
    while (!(pin_clk === 1'b1 && pin_data === 1'b0) && w < Inh + 100) begin
      @(posedge clk);
      #1 w++;
    end
    check("rts_seen", 32'(w < Inh + 100), 1);
  endtask

  task automatic dev_pulse();
    repeat (Half) @(posedge clk);
    #1 dev_clk = 1'b0;
    repeat (Half) @(posedge clk);
    #1 dev_clk = 1'b1;
  endtask

  // bits = {stop, parity, data[7:0], start}, each sampled on a device rising edge.
  task automatic dev_xfer(input bit ack, output logic [10:0] bits);
    wait_rts();
    bits[0] = pin_data;
    for (int i = 0; i < 11; i++) begin
      dev_pulse();
      if (i < 10) bits[i + 1] = pin_data;
      if (i == 9 && ack) dev_data = 1'b0;
      if (i == 10) dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 200) begin
      @(posedge clk);
      #1 w++;
    end
    check(tag, tx_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    int n, first_data, d0, e0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_hold", rx_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    rst = 1'b1;

    // 0xED: inhibit length, REQ placement, frame bits, ack.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED);
    check("accept_busy", busy, 1);
    check("accept_rx_hold", rx_hold, 1);
    check("accept_tx_ready", tx_ready, 0);
    n = 0;
    first_data = -1;
    while (clk_oe === 1'b1 && n < Inh + 50) begin
      if (data_oe === 1'b1 && first_data < 0) first_data = n;
      n++;
      @(posedge clk);
      #1;
    end
    check("inhibit_len", n, Inh + 1);
    check("req_data_oe_at", first_data, Inh);
    dev_xfer(1'b1, bits);
    check("bits_ED", {21'd0, bits}, 32'h7DA);
    wait_ready("ready_ED");
    check("done_ED", done_cnt - d0, 1);
    check("err_ED", err_cnt - e0, 0);
    check("idle_clk_oe_ED", clk_oe, 0);
    check("idle_data_oe_ED", data_oe, 0);

    // 0xFF (parity 1) and 0x01 (parity 0).
    d0 = done_cnt;
    start_tx(8'hFF);
    dev_xfer(1'b1, bits);
    check("bits_FF", {21'd0, bits}, 32'h7FE);
    wait_ready("ready_FF");
    start_tx(8'h01);
    dev_xfer(1'b1, bits);
    check("bits_01", {21'd0, bits}, 32'h402);
    wait_ready("ready_01");
    check("done_FF_01", done_cnt - d0, 2);

    // NACK: data left high at the 11th falling edge.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hC3);
    dev_xfer(1'b0, bits);
    check("bits_C3", {21'd0, bits}, 32'h786);
    wait_ready("ready_nack");
    check("nack_err", err_cnt - e0, 1);
    check("nack_done", done_cnt - d0, 0);
    check("nack_clk_oe", clk_oe, 0);
    check("nack_data_oe", data_oe, 0);

    // Timeout: device stops after the 4th falling edge and holds the clock low.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hA5);
    wait_rts();
    for (int i = 0; i < 3; i++) dev_pulse();
    repeat (Half) @(posedge clk);
    #1 dev_clk = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < To + 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("timeout_latency", n, To + 3);
    check("timeout_clk_oe", clk_oe, 0);
    check("timeout_data_oe", data_oe, 0);
    check("timeout_tx_ready", tx_ready, 1);
    dev_clk = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("timeout_err_cnt", err_cnt - e0, 1);
    check("timeout_done_cnt", done_cnt - d0, 0);

    // Busy rule: 0x55 offered mid-transfer must not disturb 0x3C.
    start_tx(8'h3C);
    repeat (10) @(posedge clk);
    #1 tx_data = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check("busy_tx_ready", tx_ready, 0);
    dev_xfer(1'b1, bits);
    check("bits_3C", {21'd0, bits}, 32'h678);
    wait_ready("ready_3C");
    repeat (Inh + 20) @(posedge clk);
    #1;
    check("busy_no_requeue", clk_oe, 0);

    // Asynchronous reset during SEND while the host is pulling data low (0x12 bit 2 = 0).
    start_tx(8'h12);
    wait_rts();
    for (int i = 0; i < 2; i++) dev_pulse();
    repeat (Half) @(posedge clk);
    #1 dev_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_data_oe", data_oe, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_clk_oe", clk_oe, 0);
    check("midrst_data_oe", data_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    dev_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_idle", tx_ready, 1);

    check("never_done_and_err", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
